// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM with memory wait handshake and sticky traps
// Moore sequencer: state-decoded controls are registered alongside the state; only ir_write,
// pc_en and retire see mem_ready/zero combinationally.
module multicycle_control #(
  parameter int OPW         = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic [OPW-1:0] opcode_i,
  input  logic           zero_i,
  input  logic           mem_ready_i,
  output logic           pc_en_o,
  output logic           ir_write_o,
  output logic           iord_o,
  output logic           mem_read_o,
  output logic           mem_write_o,
  output logic           mem_to_reg_o,
  output logic           reg_dst_o,
  output logic           reg_write_o,
  output logic           alu_src_a_o,
  output logic [1:0]     alu_src_b_o,
  output logic [1:0]     alu_op_o,
  output logic [1:0]     pc_src_o,
  output logic           retire_o,
  output logic           illegal_op_o,
  output logic           mem_timeout_o,
  output logic [3:0]     state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

  localparam int              WW         = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0]   WAIT_LIMIT = WW'(MEM_TIMEOUT);
  localparam bit              TIMEOUT_ON = (MEM_TIMEOUT != 0);

  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_REX: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_BEQ: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
      end
      S_JUMP:  c.pc_src = 2'b10;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          is_sw_q, is_sw_d;
  logic          illegal_q, timeout_q;
  logic          set_illegal, set_timeout;
  ctrl_t         ctrl_q;
  logic          in_mem_state;

  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    is_sw_d     = is_sw_q;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    // A stalled memory state either waits another cycle or, at the limit, traps.
    if (in_mem_state && !mem_ready_i) begin
      if (TIMEOUT_ON && (wait_q == WAIT_LIMIT)) begin
        state_d     = S_TRAP;
        set_timeout = 1'b1;
      end else if (TIMEOUT_ON) begin
        wait_d = wait_q + WW'(1);
      end
    end else begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          is_sw_d = (opcode_i == OP_SW);
          if (opcode_i == OP_RTYPE)                          state_d = S_REX;
          else if ((opcode_i == OP_LW) || (opcode_i == OP_SW)) state_d = S_MEMADR;
          else if (opcode_i == OP_BEQ)                       state_d = S_BEQ;
          else if (opcode_i == OP_ADDI)                      state_d = S_ADDIEX;
          else if (opcode_i == OP_J)                         state_d = S_JUMP;
          else begin
            state_d     = S_TRAP;
            set_illegal = 1'b1;
          end
        end
        S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state_d = S_MEMWB;
        S_REX:    state_d = S_ALUWB;
        S_ADDIEX: state_d = S_ADDIWB;
        S_MEMWB, S_MEMWR, S_ALUWB, S_BEQ, S_ADDIWB, S_JUMP: state_d = S_FETCH;
        default:  state_d = S_TRAP;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      is_sw_q   <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      ctrl_q    <= decode_ctrl(S_FETCH);
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      is_sw_q   <= is_sw_d;
      illegal_q <= illegal_q | set_illegal;
      timeout_q <= timeout_q | set_timeout;
      ctrl_q    <= decode_ctrl(state_d);
    end
  end

  logic active;
  assign active = !reset_i;

  assign iord_o       = active & ctrl_q.iord;
  assign mem_read_o   = active & ctrl_q.mem_read;
  assign mem_write_o  = active & ctrl_q.mem_write;
  assign mem_to_reg_o = active & ctrl_q.mem_to_reg;
  assign reg_dst_o    = active & ctrl_q.reg_dst;
  assign reg_write_o  = active & ctrl_q.reg_write;
  assign alu_src_a_o  = active & ctrl_q.alu_src_a;
  assign alu_src_b_o  = active ? ctrl_q.alu_src_b : 2'b00;
  assign alu_op_o     = active ? ctrl_q.alu_op    : 2'b00;
  assign pc_src_o     = active ? ctrl_q.pc_src    : 2'b00;

  assign ir_write_o = active & (state_q == S_FETCH) & mem_ready_i;
  assign pc_en_o    = active & (((state_q == S_FETCH) & mem_ready_i) |
                                ((state_q == S_BEQ) & zero_i) |
                                (state_q == S_JUMP));
  assign retire_o   = active & ((state_q == S_MEMWB) | (state_q == S_ALUWB) |
                                (state_q == S_ADDIWB) | (state_q == S_BEQ) |
                                (state_q == S_JUMP) | ((state_q == S_MEMWR) & mem_ready_i));

  assign illegal_op_o  = illegal_q;
  assign mem_timeout_o = timeout_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table-driven bench for multicycle_control
// Main instance uses MEM_TIMEOUT=15; a second instance with MEM_TIMEOUT=4 covers the timeout edge.
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, zero, mem_ready;
  logic [5:0] opcode;
  logic       pc_en, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       retire, illegal_op, mem_timeout;
  logic [3:0] state;

  logic       reset_t, mem_ready_t;
  logic       pc_en_t, ir_write_t, iord_t, mem_read_t, mem_write_t, mem_to_reg_t, reg_dst_t;
  logic       reg_write_t, alu_src_a_t, retire_t, illegal_op_t, mem_timeout_t;
  logic [1:0] alu_src_b_t, alu_op_t, pc_src_t;
  logic [3:0] state_t;

  multicycle_control #(.OPW(6), .MEM_TIMEOUT(15)) dut (
    .clk_i(clk), .reset_i(reset), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(mem_ready),
    .pc_en_o(pc_en), .ir_write_o(ir_write), .iord_o(iord), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .mem_to_reg_o(mem_to_reg), .reg_dst_o(reg_dst),
    .reg_write_o(reg_write), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .alu_op_o(alu_op), .pc_src_o(pc_src), .retire_o(retire), .illegal_op_o(illegal_op),
    .mem_timeout_o(mem_timeout), .state_o(state)
  );

  multicycle_control #(.OPW(6), .MEM_TIMEOUT(4)) dut_t (
    .clk_i(clk), .reset_i(reset_t), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(mem_ready_t),
    .pc_en_o(pc_en_t), .ir_write_o(ir_write_t), .iord_o(iord_t), .mem_read_o(mem_read_t),
    .mem_write_o(mem_write_t), .mem_to_reg_o(mem_to_reg_t), .reg_dst_o(reg_dst_t),
    .reg_write_o(reg_write_t), .alu_src_a_o(alu_src_a_t), .alu_src_b_o(alu_src_b_t),
    .alu_op_o(alu_op_t), .pc_src_o(pc_src_t), .retire_o(retire_t), .illegal_op_o(illegal_op_t),
    .mem_timeout_o(mem_timeout_t), .state_o(state_t)
  );

  // {pc_en, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
  //  alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0], retire}
  logic [15:0] act_ctrl, act_ctrl_t;
  assign act_ctrl   = {pc_en, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
                       alu_src_a, alu_src_b, alu_op, pc_src, retire};
  assign act_ctrl_t = {pc_en_t, ir_write_t, iord_t, mem_read_t, mem_write_t, mem_to_reg_t, reg_dst_t,
                       reg_write_t, alu_src_a_t, alu_src_b_t, alu_op_t, pc_src_t, retire_t};

  localparam logic [15:0] K_OFF  = 16'h0000;
  localparam logic [15:0] K_FR   = 16'hD020;
  localparam logic [15:0] K_FW   = 16'h1020;
  localparam logic [15:0] K_DEC  = 16'h0060;
  localparam logic [15:0] K_ADR  = 16'h00C0;
  localparam logic [15:0] K_MRD  = 16'h3000;
  localparam logic [15:0] K_MWB  = 16'h0501;
  localparam logic [15:0] K_MW1  = 16'h2801;
  localparam logic [15:0] K_MW0  = 16'h2800;
  localparam logic [15:0] K_REX  = 16'h0090;
  localparam logic [15:0] K_AWB  = 16'h0301;
  localparam logic [15:0] K_IWB  = 16'h0101;
  localparam logic [15:0] K_BEQ1 = 16'h808B;
  localparam logic [15:0] K_BEQ0 = 16'h008B;
  localparam logic [15:0] K_JMP  = 16'h8005;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        ill;
    logic        to;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;
  int rt_start, rt_end, rt_count;

  task automatic add(input logic rst, input logic [5:0] op, input logic z, input logic rdy,
                     input logic [3:0] st, input logic [15:0] ctrl, input logic ill, input logic to);
    vec_t v;
    v.rst = rst; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.ctrl = ctrl; v.ill = ill; v.to = to;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    reset_t = 1'b1; mem_ready_t = 1'b1;

    add(1, 6'h00, 0, 1, 0, K_OFF, 0, 0);
    // lw, no waits
    add(0, 6'h3F, 0, 1, 0, K_FR, 0, 0);   add(0, 6'h23, 0, 1, 1, K_DEC, 0, 0);
    add(0, 6'h3F, 0, 1, 2, K_ADR, 0, 0);  add(0, 6'h3F, 0, 1, 3, K_MRD, 0, 0);
    add(0, 6'h3F, 0, 1, 4, K_MWB, 0, 0);
    // beq taken, then not taken
    add(0, 6'h3F, 1, 1, 0, K_FR, 0, 0);   add(0, 6'h04, 1, 1, 1, K_DEC, 0, 0);
    add(0, 6'h3F, 1, 1, 8, K_BEQ1, 0, 0);
    add(0, 6'h3F, 0, 1, 0, K_FR, 0, 0);   add(0, 6'h04, 0, 1, 1, K_DEC, 0, 0);
    add(0, 6'h3F, 0, 1, 8, K_BEQ0, 0, 0);
    // lw with three wait cycles in MEMRD
    add(0, 6'h3F, 0, 1, 0, K_FR, 0, 0);   add(0, 6'h23, 0, 1, 1, K_DEC, 0, 0);
    add(0, 6'h3F, 0, 1, 2, K_ADR, 0, 0);
    add(0, 6'h3F, 0, 0, 3, K_MRD, 0, 0);  add(0, 6'h3F, 0, 0, 3, K_MRD, 0, 0);
    add(0, 6'h3F, 0, 0, 3, K_MRD, 0, 0);  add(0, 6'h3F, 0, 1, 3, K_MRD, 0, 0);
    add(0, 6'h3F, 0, 1, 4, K_MWB, 0, 0);
    // sw with one wait; opcode flips to lw in MEMADR and must be ignored
    add(0, 6'h3F, 0, 1, 0, K_FR, 0, 0);   add(0, 6'h2B, 0, 1, 1, K_DEC, 0, 0);
    add(0, 6'h23, 0, 1, 2, K_ADR, 0, 0);  add(0, 6'h23, 0, 0, 5, K_MW0, 0, 0);
    add(0, 6'h23, 0, 1, 5, K_MW1, 0, 0);
    // R-type, addi, j
    add(0, 6'h3F, 0, 1, 0, K_FR, 0, 0);   add(0, 6'h00, 0, 1, 1, K_DEC, 0, 0);
    add(0, 6'h3F, 0, 1, 6, K_REX, 0, 0);  add(0, 6'h3F, 0, 1, 7, K_AWB, 0, 0);
    add(0, 6'h3F, 0, 1, 0, K_FR, 0, 0);   add(0, 6'h08, 0, 1, 1, K_DEC, 0, 0);
    add(0, 6'h3F, 0, 1, 9, K_ADR, 0, 0);  add(0, 6'h3F, 0, 1, 10, K_IWB, 0, 0);
    add(0, 6'h3F, 0, 1, 0, K_FR, 0, 0);   add(0, 6'h02, 0, 1, 1, K_DEC, 0, 0);
    add(0, 6'h3F, 0, 1, 11, K_JMP, 0, 0);
    // fetch wait, then illegal opcode, absorbing trap, reset recovery
    add(0, 6'h3F, 0, 0, 0, K_FW, 0, 0);   add(0, 6'h3F, 0, 1, 0, K_FR, 0, 0);
    add(0, 6'h3F, 0, 1, 1, K_DEC, 0, 0);  add(0, 6'h23, 0, 1, 12, K_OFF, 1, 0);
    add(0, 6'h02, 1, 0, 12, K_OFF, 1, 0); add(1, 6'h00, 0, 1, 12, K_OFF, 1, 0);
    add(0, 6'h3F, 0, 1, 0, K_FR, 0, 0);
    // sw abandoned by reset in MEMWR
    add(0, 6'h2B, 0, 1, 1, K_DEC, 0, 0);  add(0, 6'h3F, 0, 1, 2, K_ADR, 0, 0);
    add(1, 6'h3F, 0, 1, 5, K_OFF, 0, 0);
    rt_start = vecs.size();
    // R-type then j: 4 + 3 cycles, two retires
    add(0, 6'h3F, 0, 1, 0, K_FR, 0, 0);   add(0, 6'h00, 0, 1, 1, K_DEC, 0, 0);
    add(0, 6'h3F, 0, 1, 6, K_REX, 0, 0);  add(0, 6'h3F, 0, 1, 7, K_AWB, 0, 0);
    add(0, 6'h3F, 0, 1, 0, K_FR, 0, 0);   add(0, 6'h02, 0, 1, 1, K_DEC, 0, 0);
    add(0, 6'h3F, 0, 1, 11, K_JMP, 0, 0);
    rt_end = vecs.size();
    add(0, 6'h3F, 0, 1, 0, K_FR, 0, 0);

    @(negedge clk);
    rt_count = 0;
    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; opcode = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].rdy;
      #1;
      check("state", i, 32'(state), 32'(vecs[i].st));
      check("ctrl", i, 32'(act_ctrl), 32'(vecs[i].ctrl));
      check("flags", i, 32'({illegal_op, mem_timeout}), 32'({vecs[i].ill, vecs[i].to}));
      if (i >= rt_start && i < rt_end && retire === 1'b1) rt_count++;
    end
    check("retire_count", 0, 32'(rt_count), 32'd2);

    // MEM_TIMEOUT=4: four waits then ready completes the fetch normally
    @(negedge clk); reset_t = 1'b1; mem_ready_t = 1'b0;
    @(negedge clk); reset_t = 1'b0; #1;
    for (int c = 0; c < 4; c++) begin
      check("t_wait_state", c, 32'(state_t), 32'd0);
      check("t_wait_irw", c, 32'(ir_write_t), 32'd0);
      @(negedge clk);
    end
    mem_ready_t = 1'b1; #1;
    check("t_edge_irw", 0, 32'(ir_write_t), 32'd1);
    @(negedge clk); #1;
    check("t_edge_state", 0, 32'(state_t), 32'd1);
    check("t_edge_to", 0, 32'(mem_timeout_t), 32'd0);

    // MEM_TIMEOUT=4: ready stuck low traps after five FETCH cycles
    @(negedge clk); reset_t = 1'b1; mem_ready_t = 1'b0;
    @(negedge clk); reset_t = 1'b0; #1;
    for (int c = 0; c < 5; c++) begin
      check("t_stuck_state", c, 32'(state_t), 32'd0);
      check("t_stuck_irw", c, 32'(ir_write_t), 32'd0);
      check("t_stuck_to", c, 32'(mem_timeout_t), 32'd0);
      @(negedge clk);
    end
    #1;
    for (int c = 0; c < 3; c++) begin
      check("t_trap_state", c, 32'(state_t), 32'd12);
      check("t_trap_to", c, 32'(mem_timeout_t), 32'd1);
      check("t_trap_ctrl", c, 32'(act_ctrl_t), 32'd0);
      @(negedge clk);
      mem_ready_t = 1'b1; #1;
    end
    reset_t = 1'b1;
    @(negedge clk); reset_t = 1'b0; #1;
    check("t_reset_state", 0, 32'(state_t), 32'd0);
    check("t_reset_to", 0, 32'(mem_timeout_t), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle MIPS control unit, the sequential successor to the single-cycle main decoder. A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback cycles, and drives the shared-memory, register-file, ALU and PC control signals. It adds a memory ready handshake with bounded wait states and a sticky trap on illegal opcodes or memory timeout. It sits between the instruction register / zero flag and the multi-cycle datapath.

## Interface
- OPW, 6: opcode width.
- MEM_TIMEOUT, 15: maximum consecutive wait cycles in a memory state; 0 disables the timeout.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- opcode  in  OPW  instruction register opcode field; sampled only in DECODE.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_en, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls.
- alu_src_b, alu_op, pc_src  out  2 each  datapath selects.
- retire  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal_op, mem_timeout  out  1 each  sticky fault flags.
- state  out  4  current state code, for debug.

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12.
- DECODE dispatches on opcode:
  - 000000 -> REX.
  - 100011 (lw) and 101011 (sw) -> MEMADR.
  - 000100 -> BEQ.
  - 001000 -> ADDIEX.
  - 000010 -> JUMP.
  - any other opcode -> TRAP, and illegal_op is set.
- MEMADR -> MEMRD for lw, MEMWR for sw. MEMRD -> MEMWB. REX -> ALUWB. ADDIEX -> ADDIWB.
- MEMWB, MEMWR, ALUWB, BEQ, ADDIWB and JUMP all return to FETCH.
- Outputs not listed for a state are 0.
  - FETCH: mem_read=1, alu_src_b=01, ir_write=pc_en=mem_ready.
  - DECODE: alu_src_b=11.
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10.
  - MEMRD: mem_read=1, iord=1.
  - MEMWR: mem_write=1, iord=1.
  - MEMWB: reg_write=1, mem_to_reg=1.
  - REX: alu_src_a=1, alu_op=10.
  - ALUWB: reg_write=1, reg_dst=1.
  - ADDIWB: reg_write=1.
  - BEQ: alu_src_a=1, alu_op=01, pc_src=01, pc_en=zero.
  - JUMP: pc_src=10, pc_en=1.
  - TRAP: all controls 0.
- Memory states (FETCH, MEMRD, MEMWR) hold while mem_ready=0. The access completes and the FSM advances on the cycle mem_ready=1.
- Wait counter:
  - Cleared on entry to any memory state and on every mem_ready=1 cycle.
  - Increments on each mem_ready=0 cycle spent in a memory state.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0, the next state is TRAP and mem_timeout is set.
- retire is 1 in MEMWB, MEMWR (when mem_ready=1), ALUWB, ADDIWB, BEQ and JUMP.
- TRAP is absorbing. Only reset leaves it.

## Timing
- Reset:
  - state=FETCH; wait counter, illegal_op and mem_timeout all 0.
  - While reset=1, every control output and retire are forced to 0.
  - Reset asserted mid-instruction abandons that instruction. No writes issue in the reset cycle.
- Latency with mem_ready held at 1:
  - lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
  - Each wait cycle adds 1.
- Controls are decoded from the registered state. Only ir_write, pc_en (FETCH, BEQ) and retire (MEMWR) are additionally gated combinationally by mem_ready or zero.
- Timeout boundary, with MEM_TIMEOUT=N:
  - Exactly N wait cycles are tolerated.
  - mem_ready=1 on the cycle after the N-th wait completes normally.
  - Still 0 on that cycle -> TRAP.
  - Ready in the same cycle as the limit wins.
- opcode is ignored outside DECODE. A change during any other state has no effect.
- A fault flag stays 1 until reset, and illegal_op and mem_timeout may both be 1 only if set in separate runs without an intervening reset. Since TRAP is absorbing, in practice only one is ever set per run.

## Test plan
- Reset, then mem_ready=1 and opcode=100011 -> states 0,1,2,3,4,0; reg_write=mem_to_reg=1 only in state 4; retire pulses once, 5 cycles after reset release.
- opcode=000100, zero=1, then the same with zero=0 -> pc_en=1 with pc_src=01 in BEQ when zero=1, pc_en=0 in BEQ when zero=0; each instruction is 3 cycles.
- lw with mem_ready=0 for 3 cycles in MEMRD, MEM_TIMEOUT=15 -> MEMRD held for 4 cycles, total latency 8, mem_timeout stays 0.
- FETCH with mem_ready stuck at 0, MEM_TIMEOUT=4 -> ir_write stays 0; TRAP is entered after 5 cycles in FETCH; mem_timeout=1 and all controls 0 until reset.
- opcode=111111 in DECODE -> next state 12, illegal_op=1, no reg_write or mem_write; a synchronous reset returns state to 0 and clears the flag.
- Reset asserted during MEMWR -> mem_write=0 in that cycle, state=0 on the next cycle; sequences R-type (000000) then j (000010) -> 4 + 3 cycles with exactly 2 retire pulses.
